// File: rtl/rv_dmem_arbiter_if.sv
// Bus bundle for rv_dmem_arbiter: core and dbg requester ports plus the single-port SRAM side.
// slave = the arbiter; master = requesters and SRAM together.
interface rv_dmem_arbiter_if #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DMEM_ADDR_BIT = 16
);
  logic                     core_req_i;
  logic                     core_we_i;
  logic [2:0]               core_func3_i;
  logic [XLEN-1:0]          core_addr_i;
  logic [XLEN-1:0]          core_wdata_i;
  logic                     core_gnt_o;
  logic                     core_rvalid_o;
  logic [XLEN-1:0]          core_rdata_o;
  logic                     core_err_o;

  logic                     dbg_req_i;
  logic                     dbg_we_i;
  logic [XLEN-1:0]          dbg_addr_i;
  logic [XLEN-1:0]          dbg_wdata_i;
  logic                     dbg_gnt_o;
  logic                     dbg_rvalid_o;
  logic [XLEN-1:0]          dbg_rdata_o;

  logic                     mem_en_o;
  logic [3:0]               mem_we_o;
  logic [DMEM_ADDR_BIT-3:0] mem_addr_o;
  logic [XLEN-1:0]          mem_wdata_o;
  logic [XLEN-1:0]          mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_func3_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_we_i, core_func3_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_err_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/rv_dmem_arbiter.sv
// Single-port DMEM controller: core/dbg arbitration with starvation guard, byte lanes, load extension.
// Optional RV_DMEM_MISALIGN_TRAP_EN: misaligned core accesses skip the SRAM and pulse core_err_o.
module rv_dmem_arbiter #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DMEM_ADDR_BIT = 16,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rv_dmem_arbiter_if.slave   bus
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  typedef struct packed {
    logic       valid;
    owner_e     owner;
    logic [2:0] func3;
    logic [1:0] offset;
  } resp_t;

  logic [CNT_W-1:0] starve_cnt;
  resp_t            resp_q;
  logic             err_q;

  logic             dbg_win_c;
  logic             core_win_c;
  logic             size_b_c;
  logic             size_h_c;
  logic             trap_c;
  logic [1:0]       core_off_c;
  logic [3:0]       core_mask_c;
  logic [XLEN-1:0]  core_wdata_c;
  logic [XLEN-1:0]  lane_c;
  logic [XLEN-1:0]  load_c;
  logic             addr_unused;

  // Core has priority unless dbg has been denied STARVE_LIMIT cycles in a row
  assign dbg_win_c  = rst_n && bus.dbg_req_i &&
                      (!bus.core_req_i || (starve_cnt == STARVE_MAX));
  assign core_win_c = rst_n && bus.core_req_i && !dbg_win_c;

  assign bus.dbg_gnt_o  = dbg_win_c;
  assign bus.core_gnt_o = core_win_c;

  assign size_b_c = (bus.core_func3_i[1:0] == 2'd0);
  assign size_h_c = (bus.core_func3_i[1:0] == 2'd1);

  // Force-aligned lane offset, byte mask and lane-replicated store data
  always_comb begin
    core_off_c   = 2'b00;
    core_mask_c  = 4'b1111;
    core_wdata_c = bus.core_wdata_i;
    if (size_b_c) begin
      core_off_c   = bus.core_addr_i[1:0];
      core_mask_c  = 4'(4'b0001 << bus.core_addr_i[1:0]);
      core_wdata_c = {LANES{bus.core_wdata_i[7:0]}};
    end else if (size_h_c) begin
      core_off_c   = {bus.core_addr_i[1], 1'b0};
      core_mask_c  = bus.core_addr_i[1] ? 4'b1100 : 4'b0011;
      core_wdata_c = {(LANES / 2){bus.core_wdata_i[15:0]}};
    end
  end

`ifdef RV_DMEM_MISALIGN_TRAP_EN
  assign trap_c = (size_h_c && bus.core_addr_i[0]) ||
                  (!size_b_c && !size_h_c && (bus.core_addr_i[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  // SRAM request for whichever port won this cycle
  always_comb begin
    bus.mem_en_o    = 1'b0;
    bus.mem_we_o    = 4'b0000;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (dbg_win_c) begin
      bus.mem_en_o    = 1'b1;
      bus.mem_we_o    = bus.dbg_we_i ? 4'b1111 : 4'b0000;
      bus.mem_addr_o  = bus.dbg_addr_i[DMEM_ADDR_BIT-1:2];
      bus.mem_wdata_o = bus.dbg_wdata_i;
    end else if (core_win_c) begin
      bus.mem_en_o    = !trap_c;
      bus.mem_we_o    = (bus.core_we_i && !trap_c) ? core_mask_c : 4'b0000;
      bus.mem_addr_o  = bus.core_addr_i[DMEM_ADDR_BIT-1:2];
      bus.mem_wdata_o = core_wdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      resp_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      resp_q.valid  <= (dbg_win_c && !bus.dbg_we_i) ||
                       (core_win_c && !bus.core_we_i && !trap_c);
      resp_q.owner  <= dbg_win_c ? OWN_DBG : OWN_CORE;
      resp_q.func3  <= bus.core_func3_i;
      resp_q.offset <= core_off_c;
      err_q         <= core_win_c && trap_c;
      if (!bus.dbg_req_i || dbg_win_c) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Load extraction uses the access shape captured in the grant cycle
  assign lane_c = bus.mem_rdata_i >> {resp_q.offset, 3'b000};

  always_comb begin
    load_c = lane_c;
    case (resp_q.func3)
      3'd0:    load_c = {{(XLEN - 8){lane_c[7]}}, lane_c[7:0]};
      3'd1:    load_c = {{(XLEN - 16){lane_c[15]}}, lane_c[15:0]};
      3'd4:    load_c = {{(XLEN - 8){1'b0}}, lane_c[7:0]};
      3'd5:    load_c = {{(XLEN - 16){1'b0}}, lane_c[15:0]};
      default: load_c = lane_c;
    endcase
  end

  assign bus.core_rvalid_o = resp_q.valid && (resp_q.owner == OWN_CORE);
  assign bus.dbg_rvalid_o  = resp_q.valid && (resp_q.owner == OWN_DBG);
  assign bus.core_err_o    = err_q;
  assign bus.core_rdata_o  = bus.core_rvalid_o ? load_c : '0;
  assign bus.dbg_rdata_o   = bus.dbg_rvalid_o ? bus.mem_rdata_i : '0;

  // Upper address bits wrap; dbg is always word-aligned
  assign addr_unused = ^{bus.core_addr_i[XLEN-1:DMEM_ADDR_BIT],
                         bus.dbg_addr_i[XLEN-1:DMEM_ADDR_BIT],
                         bus.dbg_addr_i[1:0]};

endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Testbench for rv_dmem_arbiter: directed cases then random traffic against a byte-level memory model.
module tb_rv_dmem_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AB    = 16;
  localparam int unsigned LIMIT = 4;
`ifdef RV_DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_dmem_arbiter_if #(.XLEN(XLEN), .DMEM_ADDR_BIT(AB)) bif ();

  rv_dmem_arbiter #(.XLEN(XLEN), .DMEM_ADDR_BIT(AB), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // SRAM behaviour: synchronous write with byte enables, read word one cycle later
  logic [31:0] sram [0:16383];
  logic [31:0] sram_q;
  logic [31:0] we_mask;
  assign we_mask = {{8{bif.mem_we_o[3]}}, {8{bif.mem_we_o[2]}},
                    {8{bif.mem_we_o[1]}}, {8{bif.mem_we_o[0]}}};
  always @(posedge clk) begin
    if (bif.mem_en_o) begin
      sram[bif.mem_addr_o] <= (sram[bif.mem_addr_o] & ~we_mask) | (bif.mem_wdata_o & we_mask);
      sram_q <= sram[bif.mem_addr_o];
    end
  end
  assign bif.mem_rdata_i = sram_q;

  // Reference: byte-addressed memory (the used 64-byte window) and a denied-cycle count
  logic [7:0]  ref_bytes [0:63];
  int unsigned denied;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        m_cg, m_dg;
  logic        obs_cg, obs_en, obs_crv, obs_err;
  logic [3:0]  obs_we;
  logic [13:0] obs_addr;
  logic [31:0] obs_wd, obs_crd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned n_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned a, input int unsigned n, input bit sgn);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < int'(n); i++) v = v | (32'(ref_bytes[(a + 32'(i)) % 64]) << (8 * i));
    if (sgn && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sgn && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input int unsigned a, input int unsigned n, input logic [31:0] w);
    for (int i = 0; i < int'(n); i++) ref_bytes[(a + 32'(i)) % 64] = 8'(w >> (8 * i));
  endtask

  task automatic set_idle();
    bif.core_req_i   = 1'b0;
    bif.core_we_i    = 1'b0;
    bif.core_func3_i = 3'd0;
    bif.core_addr_i  = '0;
    bif.core_wdata_i = '0;
    bif.dbg_req_i    = 1'b0;
    bif.dbg_we_i     = 1'b0;
    bif.dbg_addr_i   = '0;
    bif.dbg_wdata_i  = '0;
  endtask

  // One clock cycle: check grant-cycle outputs, advance, check the response cycle
  task automatic step();
    logic exp_cg, exp_dg, exp_en, exp_crv, exp_drv, exp_err, wr, trap;
    logic [3:0]  exp_we;
    logic [13:0] exp_addr;
    logic [31:0] exp_wd, exp_crd, exp_drd, w;
    int unsigned a, n;
    exp_en = 0; exp_crv = 0; exp_drv = 0; exp_err = 0; wr = 0; trap = 0;
    exp_we = '0; exp_addr = '0; exp_wd = '0; exp_crd = '0; exp_drd = '0; w = '0;
    a = 0; n = 4;
    #1;
    exp_dg = rst_n && bif.dbg_req_i && (!bif.core_req_i || denied == LIMIT);
    exp_cg = rst_n && bif.core_req_i && !exp_dg;
    chk("core_gnt", 32'(bif.core_gnt_o), 32'(exp_cg));
    chk("dbg_gnt",  32'(bif.dbg_gnt_o),  32'(exp_dg));
    if (exp_dg) begin
      a = 32'(bif.dbg_addr_i[15:0]);
      a = a - a % 4;
      wr = bif.dbg_we_i;
      w = bif.dbg_wdata_i;
      exp_wd = w;
    end else if (exp_cg) begin
      n = n_of(bif.core_func3_i);
      a = 32'(bif.core_addr_i[15:0]);
      trap = TRAP_EN && (a % n != 0);
      a = a - a % n;
      wr = bif.core_we_i;
      w = bif.core_wdata_i;
      exp_wd = (n == 1) ? {4{w[7:0]}} : (n == 2) ? {2{w[15:0]}} : w;
    end
    if (exp_dg || exp_cg) begin
      exp_en = !trap;
      exp_addr = 14'(a / 4);
      if (trap) exp_err = 1;
      else if (wr) begin
        exp_we = 4'(((1 << n) - 1) << (a % 4));
        ref_store(a, n, w);
      end else if (exp_dg) begin
        exp_drv = 1;
        exp_drd = ref_load(a, 4, 1'b0);
      end else begin
        exp_crv = 1;
        exp_crd = ref_load(a, n, bif.core_func3_i == 3'd0 || bif.core_func3_i == 3'd1);
      end
    end
    chk("mem_en", 32'(bif.mem_en_o), 32'(exp_en));
    if (exp_en) begin
      chk("mem_addr", 32'(bif.mem_addr_o), 32'(exp_addr));
      chk("mem_we",   32'(bif.mem_we_o),   32'(exp_we));
      if (wr) chk("mem_wdata", bif.mem_wdata_o, exp_wd);
    end
    obs_cg = bif.core_gnt_o; obs_en = bif.mem_en_o; obs_we = bif.mem_we_o;
    obs_addr = bif.mem_addr_o; obs_wd = bif.mem_wdata_o;
    if (!rst_n) denied = 0;
    else if (bif.dbg_req_i && !exp_dg) denied = (denied == LIMIT) ? LIMIT : denied + 1;
    else denied = 0;
    m_cg = exp_cg; m_dg = exp_dg;
    @(posedge clk); #1;
    chk("core_rvalid", 32'(bif.core_rvalid_o), 32'(exp_crv));
    chk("dbg_rvalid",  32'(bif.dbg_rvalid_o),  32'(exp_drv));
    chk("core_err",    32'(bif.core_err_o),    32'(exp_err));
    if (exp_crv) chk("core_rdata", bif.core_rdata_o, exp_crd);
    if (exp_drv) chk("dbg_rdata",  bif.dbg_rdata_o,  exp_drd);
    obs_crv = bif.core_rvalid_o; obs_err = bif.core_err_o; obs_crd = bif.core_rdata_o;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    denied = 0;
    #1;
    chk("rst_core_gnt",    32'(bif.core_gnt_o),    32'd0);
    chk("rst_dbg_gnt",     32'(bif.dbg_gnt_o),     32'd0);
    chk("rst_core_rvalid", 32'(bif.core_rvalid_o), 32'd0);
    chk("rst_dbg_rvalid",  32'(bif.dbg_rvalid_o),  32'd0);
    chk("rst_core_err",    32'(bif.core_err_o),    32'd0);
    chk("rst_mem_en",      32'(bif.mem_en_o),      32'd0);
    chk("rst_mem_we",      32'(bif.mem_we_o),      32'd0);
    chk("rst_core_rdata",  bif.core_rdata_o,       32'd0);
    chk("rst_dbg_rdata",   bif.dbg_rdata_o,        32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_core_rvalid", 32'(bif.core_rvalid_o), 32'd0);
    chk("rel_dbg_rvalid",  32'(bif.dbg_rvalid_o),  32'd0);
  endtask

  task automatic core_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    set_idle();
    bif.core_req_i = 1'b1; bif.core_we_i = we; bif.core_func3_i = f3;
    bif.core_addr_i = addr; bif.core_wdata_i = wdata;
    step();
    set_idle();
  endtask

  task automatic both_req(input int cycles, output logic [5:0] pat);
    pat = '0;
    set_idle();
    bif.core_req_i = 1'b1; bif.core_func3_i = 3'd2; bif.core_addr_i = 32'h0;
    bif.dbg_req_i  = 1'b1; bif.dbg_addr_i  = 32'h20;
    for (int i = 0; i < cycles; i++) begin
      step();
      pat[i] = obs_cg;
    end
    set_idle();
  endtask

  initial begin
    logic [5:0]  pat;
    logic [5:0]  exp_pat;
    logic        cpend, dpend;
    logic [2:0]  st_f3 [6];
    st_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'h00;
    m_cg = 0; m_dg = 0;
    do_reset();

    // Preload the 16-word window through the dbg port
    for (int i = 0; i < 16; i++) begin
      set_idle();
      bif.dbg_req_i = 1'b1; bif.dbg_we_i = 1'b1;
      bif.dbg_addr_i = 32'(4 * i); bif.dbg_wdata_i = $urandom;
      step();
    end
    set_idle();

    core_op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
    chk("sw_we",    32'(obs_we),   32'h0000_000F);
    chk("sw_addr",  32'(obs_addr), 32'd4);
    chk("sw_wdata", obs_wd,        32'hDEAD_BEEF);
    core_op(1'b0, 3'd2, 32'h10, 32'h0);
    chk("lw_rvalid", 32'(obs_crv), 32'd1);
    chk("lw_rdata",  obs_crd,      32'hDEAD_BEEF);

    core_op(1'b1, 3'd0, 32'h13, 32'hABCD_EF80);
    chk("sb_we",    32'(obs_we), 32'h0000_0008);
    chk("sb_wdata", obs_wd,      32'h8080_8080);
    core_op(1'b0, 3'd0, 32'h13, 32'h0);
    chk("lb_rdata", obs_crd, 32'hFFFF_FF80);
    core_op(1'b0, 3'd4, 32'h13, 32'h0);
    chk("lbu_rdata", obs_crd, 32'h0000_0080);

    core_op(1'b1, 3'd1, 32'h22, 32'h1234_8001);
    chk("sh_we",    32'(obs_we), 32'h0000_000C);
    chk("sh_wdata", obs_wd,      32'h8001_8001);
    core_op(1'b0, 3'd1, 32'h22, 32'h0);
    chk("lh_rdata", obs_crd, 32'hFFFF_8001);
    core_op(1'b0, 3'd5, 32'h22, 32'h0);
    chk("lhu_rdata", obs_crd, 32'h0000_8001);

    core_op(1'b0, 3'd2, 32'h2, 32'h0);
    chk("mis_gnt",    32'(obs_cg),  32'd1);
    chk("mis_mem_en", 32'(obs_en),  32'(!TRAP_EN));
    chk("mis_err",    32'(obs_err), 32'(TRAP_EN));
    chk("mis_rvalid", 32'(obs_crv), 32'(!TRAP_EN));

    exp_pat = 6'b101111;
    both_req(6, pat);
    chk("starve_pattern", 32'(pat), 32'(exp_pat));

    // Reset in the response cycle of a dbg read
    set_idle();
    bif.dbg_req_i = 1'b1; bif.dbg_addr_i = 32'h10;
    #1;
    chk("rr_dbg_gnt", 32'(bif.dbg_gnt_o), 32'd1);
    @(posedge clk); #1;
    chk("rr_dbg_rvalid", 32'(bif.dbg_rvalid_o), 32'd1);
    do_reset();
    step();

    // Reset with a partially built starvation count
    both_req(2, pat);
    do_reset();
    both_req(6, pat);
    chk("starve_after_rst", 32'(pat), 32'(exp_pat));

    // Random traffic; each requester holds its request until granted
    cpend = 0; dpend = 0;
    repeat (400) begin
      if (!cpend && $urandom_range(0, 9) < 6) begin
        cpend = 1;
        bif.core_we_i = 1'($urandom_range(0, 1));
        bif.core_func3_i = bif.core_we_i ? st_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
        bif.core_addr_i = $urandom & 32'hFFFF_003F;
        bif.core_wdata_i = $urandom;
      end
      if (!dpend && $urandom_range(0, 9) < 3) begin
        dpend = 1;
        bif.dbg_we_i = 1'($urandom_range(0, 1));
        bif.dbg_addr_i = $urandom & 32'hFFFF_003F;
        bif.dbg_wdata_i = $urandom;
      end
      bif.core_req_i = cpend;
      bif.dbg_req_i  = dpend;
      step();
      if (m_cg) cpend = 0;
      if (m_dg) dpend = 0;
    end
    set_idle();
    step();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_dmem_arbiter.md
Name: rv_dmem_arbiter

Overview:
- Single-port data-memory controller that shares DMEM between the pipeline's load/store path (core port) and an external loader/debug port (dbg port).
- Core has priority; a starvation counter guarantees the dbg port a grant.
- Generates byte enables and store-data lane replication from func3 (BYTE/HALF/WORD/BYTEU/HALFU encodings).
- Extracts and sign/zero-extends load data, then returns it with a 1-cycle response latency.

Parameters:
- XLEN, 32, data/address width of both requester ports.
- DMEM_ADDR_BIT, 16, byte-address bits decoded; word index is addr[DMEM_ADDR_BIT-1:2].
- STARVE_LIMIT, 4, consecutive denied dbg cycles before dbg is forced ahead of core; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  1  core access request
- core_we_i  in  1  1=store, 0=load
- core_func3_i  in  3  access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU)
- core_addr_i  in  XLEN  byte address
- core_wdata_i  in  XLEN  store data, right-aligned
- core_gnt_o  out  1  request accepted this cycle
- core_rvalid_o  out  1  load data valid
- core_rdata_o  out  XLEN  extended load data
- core_err_o  out  1  misaligned-access pulse (optional feature)
- dbg_req_i, dbg_we_i  in  1  dbg request / write; always full-word
- dbg_addr_i  in  XLEN  byte address; bits [1:0] ignored
- dbg_wdata_i  in  XLEN  write data
- dbg_gnt_o, dbg_rvalid_o  out  1  grant / read valid
- dbg_rdata_o  out  XLEN  raw read word
- mem_en_o  out  1  SRAM access enable
- mem_we_o  out  4  byte write enables; 0 for reads
- mem_addr_o  out  DMEM_ADDR_BIT-2  word index
- mem_wdata_o  out  XLEN  lane-replicated write data
- mem_rdata_i  in  XLEN  SRAM read word, valid the cycle after a read enable

Behaviour:
- Grant is combinational in the request cycle. At most one of core_gnt_o and dbg_gnt_o is high per cycle.
- Priority:
  - dbg wins if dbg_req_i && (!core_req_i || starve_cnt == STARVE_LIMIT).
  - Otherwise core wins when requesting.
- starve_cnt (4b):
  - +1 each cycle with dbg_req_i && !dbg_gnt_o, saturating at STARVE_LIMIT.
  - Cleared on dbg grant or when dbg_req_i is low.
- The requester holds its request stable until granted. Address bits above DMEM_ADDR_BIT are ignored (wrap).
- Stores, offset o = addr[1:0]:
  - B: mem_we_o = 4'b0001<<o; wdata byte replicated to all 4 lanes.
  - H: mem_we_o = 4'b0011<<o; wdata halfword replicated to both halves.
  - W: mem_we_o = 4'b1111.
  - func3 3/6/7 are treated as W.
- Loads: mem_en_o=1, mem_we_o=0. A response register captures {owner, func3, offset}.
- Next cycle, the owner's rvalid is pulsed for exactly 1 cycle.
  - Core rdata: selected byte/half, sign-extended for B/H, zero-extended for BU/HU, full word for W.
  - dbg rdata: raw word.
- Stores produce no rvalid.
- Back-to-back grants every cycle are supported. A response and a new grant in the same cycle are independent.
- Reset values:
  - All *_gnt_o, *_rvalid_o, core_err_o, mem_en_o = 0.
  - mem_we_o = 0; rdata outputs = 0.
  - starve_cnt = 0; response register invalid.
- Reset asserted mid-read discards the pending response; no rvalid follows after release.

Optional Feature:
- Macro: RV_DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned core access (H/HU with addr[0]=1, W with addr[1:0]!=0) is still granted.
  - mem_en_o stays 0 (no SRAM access, no write).
  - core_err_o pulses 1 cycle later, in place of core_rvalid_o.
- Undefined:
  - Offset is force-aligned: H uses {addr[1],1'b0}; W uses 0.
  - The access proceeds normally; core_err_o is tied 0.

Test Plan:
- Reset then core SW addr 0x10 data 0xDEADBEEF, core LW 0x10 -> mem_we_o=4'hF, mem_addr_o=4; next-cycle core_rvalid_o=1, core_rdata_o=0xDEADBEEF.
- Byte access:
  - Stimulus: SB 0x80 to addr 0x13, then LB 0x13 and LBU 0x13.
  - Required: mem_we_o=4'b1000 and mem_wdata_o=0x80808080 on the store; load data 0xFFFFFF80 (LB) and 0x00000080 (LBU).
- Halfword access:
  - Stimulus: SH 0x8001 to addr 0x22, then LH and LHU at 0x22.
  - Required: mem_we_o=4'b1100; load data 0xFFFF8001 (LH) and 0x00008001 (LHU).
- Starvation: core_req_i and dbg_req_i both held high with STARVE_LIMIT=4 -> core granted 4 cycles, dbg granted on cycle 5, core on cycle 6.
- Reset mid-operation: assert rst_n low the cycle after a dbg LW grant -> no dbg_rvalid_o after release; starve_cnt restarts at 0.
- Misaligned access: with RV_DMEM_MISALIGN_TRAP_EN, core LW addr 0x2 -> core_gnt_o=1, mem_en_o=0, core_err_o=1 next cycle, no rvalid; without the macro, the same access reads word 0 and core_err_o stays 0.
